mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Ports, in order (name, direction, width, meaning):
- clk_i, in, 1: clock; all state updates on the rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- reg_waddr_i, in, RADDR_WIDTH: destination register from exe.
- reg_we_i, in, 1: register write enable from exe.
- reg_wdata_i, in, DATA_WIDTH: ALU result from exe.
- mem_addr_i, in, ADDR_WIDTH: byte address from exe.
- mem_data_i, in, DATA_WIDTH: store data from exe.
- mem_we_i, in, 1: store flag from exe.
- mem_op_i, in, 4: memory op code (MEM_NOP/SB/SH/SW/LB/LH/LW/LBU/LHU, as in defines.v).
- stall_o, out, 1: combinational; upstream holds all inputs while high.
- dbus_req_o, out, 1: data bus request.
- dbus_we_o, out, 1: bus write.
- dbus_addr_o, out, ADDR_WIDTH: word-aligned address; bits [1:0] are always 0.
- dbus_wdata_o, out, DATA_WIDTH: lane-positioned store data.
- dbus_be_o, out, 4: byte enables.
- dbus_ack_i, in, 1: one-cycle completion.
- dbus_rdata_i, in, DATA_WIDTH: read word, valid when dbus_ack_i is high.
- wb_reg_waddr_o, out, RADDR_WIDTH: to writeback.
- wb_reg_we_o, out, 1: to writeback.
- wb_reg_wdata_o, out, DATA_WIDTH: to writeback.
- misalign_o, out, 1: present only with MEM_MISALIGN_TRAP_EN.
- misalign_addr_o, out, ADDR_WIDTH: present only with MEM_MISALIGN_TRAP_EN.

Function
REQ-002 The block SHALL have two states:
- IDLE: no bus transaction in progress.
- BUS: bus transaction in progress.
REQ-003 IDLE, mem_op_i == MEM_NOP:
- At the next edge, the wb_* outputs SHALL equal the reg_* inputs (1-cycle latency).
- stall_o SHALL be 0.
REQ-004 IDLE, mem_op_i != MEM_NOP:
- stall_o SHALL be 1.
- At the next edge the block SHALL latch op, address, data and waddr, and enter BUS.
- At that same edge, wb_reg_we_o SHALL go to 0 (bubble).
REQ-005 In BUS, the block SHALL drive the following from registers and ignore the exe inputs:
- dbus_req_o = 1.
- dbus_we_o = 1 for SB/SH/SW.
- dbus_addr_o = {addr[31:2], 2'b00}.
REQ-006 In BUS, stall_o SHALL equal !dbus_ack_i; each BUS cycle without ack SHALL leave wb_reg_we_o at 0.
REQ-007 On the edge where BUS sees dbus_ack_i = 1, the block SHALL:
- return to IDLE;
- drop dbus_req_o;
- for a load, set wb_reg_we_o = 1 with the extracted data and latched waddr;
- for a store, set wb_reg_we_o = 0.
REQ-008 Store lane and enable formatting:
- SB: wdata = byte replicated ×4; be = 4'b0001 << addr[1:0].
- SH: wdata = half replicated ×2; be = addr[1] ? 4'b1100 : 4'b0011.
- SW: be = 4'b1111.
REQ-009 Load extraction:
- LB/LBU: byte at addr[1:0], sign- or zero-extended respectively.
- LH/LHU: half at addr[1], sign- or zero-extended respectively.
- LW: full word.
REQ-010 Every load SHALL drive dbus_be_o = 4'b1111.
REQ-011 An unlisted mem_op_i code SHALL be treated as MEM_NOP.
REQ-012 dbus_ack_i SHALL be ignored in IDLE.
REQ-013 Back-to-back memory ops SHALL each take at least 2 cycles, with no lost or duplicated writeback.

Reset
REQ-014 While rst_i = 1, asynchronously:
- state SHALL be IDLE.
- All outputs SHALL be 0, including dbus_req_o and wb_reg_we_o.
REQ-015 A reset asserted during BUS SHALL abandon the transaction with no writeback; a later dbus_ack_i SHALL be ignored.

Configuration
REQ-016 With MEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL:
- stay in IDLE and issue no bus request;
- pulse misalign_o for 1 cycle;
- load misalign_addr_o with mem_addr_i;
- keep wb_reg_we_o at 0;
- hold stall_o at 0.
Misaligned means SH/LH/LHU with addr[0] = 1, or SW/LW with addr[1:0] != 0.
REQ-017 Without MEM_MISALIGN_TRAP_EN:
- misalign_o and misalign_addr_o SHALL be absent.
- Halfword ops SHALL use addr[1] only; word ops SHALL ignore addr[1:0].

Verification
REQ-018 Non-memory op, reg_waddr_i = 5, reg_wdata_i = 0x1234 -> next cycle: wb_reg_we_o = 1, waddr 5, wdata 0x1234, stall_o = 0.
REQ-019 SB, addr 0x103, data 0xAB, ack after 3 BUS cycles -> dbus_addr_o = 0x100, be = 4'b1000, wdata = 0xABABABAB; stall_o high through the ack-less cycles; no writeback.
REQ-020 LB, addr 0x102, rdata 0x0080FF00, ack on the first BUS cycle -> wb_reg_wdata_o = 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-021 LH, addr 0x2, rdata 0x8001_0000 -> 0xFFFF8001; LW then SW back-to-back -> two transactions and exactly one writeback.
REQ-022 rst_i pulsed during BUS -> dbus_req_o falls immediately; a subsequent ack produces no writeback.
REQ-023 With MEM_MISALIGN_TRAP_EN: LW at 0x6 -> no dbus_req_o, misalign_o = 1 for 1 cycle, misalign_addr_o = 0x6.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns exe-stage load/store ops into single-beat data bus
// transactions. Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access #(
    parameter int RADDR_WIDTH = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic                   mem_we_i,
    input  logic [3:0]             mem_op_i,
    output logic                   stall_o,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
    output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
    output logic [3:0]             dbus_be_o,
    input  logic                   dbus_ack_i,
    input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
    output logic [RADDR_WIDTH-1:0] wb_reg_waddr_o,
    output logic                   wb_reg_we_o,
    output logic [DATA_WIDTH-1:0]  wb_reg_wdata_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                   misalign_o,
    output logic [ADDR_WIDTH-1:0]  misalign_addr_o
`endif
);

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_SB  = 4'd1;
    localparam logic [3:0] MEM_SH  = 4'd2;
    localparam logic [3:0] MEM_SW  = 4'd3;
    localparam logic [3:0] MEM_LB  = 4'd4;
    localparam logic [3:0] MEM_LH  = 4'd5;
    localparam logic [3:0] MEM_LW  = 4'd6;
    localparam logic [3:0] MEM_LBU = 4'd7;
    localparam logic [3:0] MEM_LHU = 4'd8;

    typedef enum logic {
        ST_IDLE,
        ST_BUS
    } state_t;

    state_t state_q, state_d;

    logic [3:0]             op_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [RADDR_WIDTH-1:0] waddr_q;

    logic                   op_is_mem;
    logic                   misaligned;
    logic                   take_op;
    logic                   stall;
    logic [7:0]             load_byte;
    logic [15:0]            load_half;
    logic [DATA_WIDTH-1:0]  load_data;

    // Store direction is decoded from the op code; the exe store flag carries no extra information.
    logic unused_mem_we;
    assign unused_mem_we = mem_we_i;

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    // Unlisted codes fall out of both decoders and therefore behave as MEM_NOP.
    assign op_is_mem = is_store(mem_op_i) || is_load(mem_op_i);

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (mem_op_i)
            MEM_SH, MEM_LH, MEM_LHU: misaligned = mem_addr_i[0];
            MEM_SW, MEM_LW:          misaligned = |mem_addr_i[1:0];
            default:                 misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign take_op = op_is_mem && !misaligned;

    // Handshake: stall_o low means exe may advance at the next edge; while high exe holds
    // every input stable. dbus_req_o stays high until the bus returns a one-cycle dbus_ack_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take_op) begin
                    state_d = ST_BUS;
                    stall   = 1'b1;
                end
            end
            ST_BUS: begin
                stall = !dbus_ack_i;
                if (dbus_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stall_o = stall & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q    <= MEM_NOP;
            addr_q  <= '0;
            data_q  <= '0;
            waddr_q <= '0;
        end else if ((state_q == ST_IDLE) && take_op) begin
            op_q    <= mem_op_i;
            addr_q  <= mem_addr_i;
            data_q  <= mem_data_i;
            waddr_q <= reg_waddr_i;
        end
    end

    always_comb begin
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = '0;
        dbus_wdata_o = '0;
        dbus_be_o    = 4'b0000;
        if (state_q == ST_BUS) begin
            dbus_req_o  = 1'b1;
            dbus_we_o   = is_store(op_q);
            dbus_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            case (op_q)
                MEM_SB: begin
                    dbus_wdata_o = {4{data_q[7:0]}};
                    dbus_be_o    = 4'b0001 << addr_q[1:0];
                end
                MEM_SH: begin
                    dbus_wdata_o = {2{data_q[15:0]}};
                    dbus_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
                end
                MEM_SW: begin
                    dbus_wdata_o = data_q;
                    dbus_be_o    = 4'b1111;
                end
                default: begin
                    dbus_be_o = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        load_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    load_byte = dbus_rdata_i[7:0];
            2'd1:    load_byte = dbus_rdata_i[15:8];
            2'd2:    load_byte = dbus_rdata_i[23:16];
            default: load_byte = dbus_rdata_i[31:24];
        endcase
        load_half = addr_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (op_q)
            MEM_LB:  load_data = {{24{load_byte[7]}}, load_byte};
            MEM_LBU: load_data = {24'd0, load_byte};
            MEM_LH:  load_data = {{16{load_half[15]}}, load_half};
            MEM_LHU: load_data = {16'd0, load_half};
            default: load_data = dbus_rdata_i;
        endcase
    end

    // A memory op always inserts a bubble; its own writeback (loads only) lands on the ack edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_reg_waddr_o <= '0;
            wb_reg_we_o    <= 1'b0;
            wb_reg_wdata_o <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_is_mem) begin
                        wb_reg_we_o <= 1'b0;
                    end else begin
                        wb_reg_waddr_o <= reg_waddr_i;
                        wb_reg_we_o    <= reg_we_i;
                        wb_reg_wdata_o <= reg_wdata_i;
                    end
                end
                ST_BUS: begin
                    if (dbus_ack_i && is_load(op_q)) begin
                        wb_reg_waddr_o <= waddr_q;
                        wb_reg_we_o    <= 1'b1;
                        wb_reg_wdata_o <= load_data;
                    end else begin
                        wb_reg_we_o <= 1'b0;
                    end
                end
                default: wb_reg_we_o <= 1'b0;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            misalign_o <= (state_q == ST_IDLE) && misaligned;
            if ((state_q == ST_IDLE) && misaligned) begin
                misalign_addr_o <= mem_addr_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed bus/writeback cases plus a random op mix,
// with a writeback scoreboard. Define MEM_MISALIGN_TRAP_EN to exercise the trap build.
module tb_mem_access;

    localparam int RW = 5;
    localparam int DW = 32;
    localparam int AW = 32;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_SB  = 4'd1;
    localparam logic [3:0] OP_SH  = 4'd2;
    localparam logic [3:0] OP_SW  = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LH  = 4'd5;
    localparam logic [3:0] OP_LW  = 4'd6;
    localparam logic [3:0] OP_LBU = 4'd7;
    localparam logic [3:0] OP_LHU = 4'd8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [RW-1:0] reg_waddr_i;
    logic          reg_we_i;
    logic [DW-1:0] reg_wdata_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_data_i;
    logic          mem_we_i;
    logic [3:0]    mem_op_i;
    logic          stall_o;
    logic          dbus_req_o;
    logic          dbus_we_o;
    logic [AW-1:0] dbus_addr_o;
    logic [DW-1:0] dbus_wdata_o;
    logic [3:0]    dbus_be_o;
    logic          dbus_ack_i;
    logic [DW-1:0] dbus_rdata_i;
    logic [RW-1:0] wb_reg_waddr_o;
    logic          wb_reg_we_o;
    logic [DW-1:0] wb_reg_wdata_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic          misalign_o;
    logic [AW-1:0] misalign_addr_o;
`endif

    mem_access #(.RADDR_WIDTH(RW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .reg_waddr_i    (reg_waddr_i),
        .reg_we_i       (reg_we_i),
        .reg_wdata_i    (reg_wdata_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_we_i       (mem_we_i),
        .mem_op_i       (mem_op_i),
        .stall_o        (stall_o),
        .dbus_req_o     (dbus_req_o),
        .dbus_we_o      (dbus_we_o),
        .dbus_addr_o    (dbus_addr_o),
        .dbus_wdata_o   (dbus_wdata_o),
        .dbus_be_o      (dbus_be_o),
        .dbus_ack_i     (dbus_ack_i),
        .dbus_rdata_i   (dbus_rdata_i),
        .wb_reg_waddr_o (wb_reg_waddr_o),
        .wb_reg_we_o    (wb_reg_we_o),
        .wb_reg_wdata_o (wb_reg_wdata_o)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_o     (misalign_o),
        .misalign_addr_o(misalign_addr_o)
`endif
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    // Scoreboard
    int n_vec = 0;
    int n_err = 0;
    logic [RW+DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && (wb_reg_we_o === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("wb_spurious", {63'd0, wb_reg_we_o}, 64'd0);
            end else begin
                check("wb_data", {wb_reg_waddr_o, wb_reg_wdata_o}, exp_q.pop_front());
            end
        end
    end

    // Reference model
    function automatic logic [31:0] load_model(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] w);
        logic [7:0]  b [4];
        logic [7:0]  sel_b;
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        sel_b = b[addr[1:0]];
        h = addr[1] ? {b[3], b[2]} : {b[1], b[0]};
        case (op)
            OP_LB:   return {{24{sel_b[7]}}, sel_b};
            OP_LBU:  return {24'd0, sel_b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            OP_SB:   return 4'(1 << addr[1:0]);
            OP_SH:   return addr[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            OP_SH:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    // Drivers: each task starts and ends 1 time unit after a rising edge.
    task automatic alu_op(input logic [4:0] waddr, input logic [31:0] wdata, input logic we,
                          input logic [3:0] op_code, input logic ack);
        mem_op_i    = op_code;
        mem_addr_i  = $urandom;
        mem_data_i  = $urandom;
        mem_we_i    = 1'b0;
        reg_waddr_i = waddr;
        reg_wdata_i = wdata;
        reg_we_i    = we;
        dbus_ack_i  = ack;
        if (we) exp_q.push_back({waddr, wdata});
        @(negedge clk_i);
        check("alu_stall", {63'd0, stall_o}, 64'd0);
        check("alu_req", {63'd0, dbus_req_o}, 64'd0);
        @(posedge clk_i); #1;
        dbus_ack_i = 1'b0;
        check("alu_wb_we", {63'd0, wb_reg_we_o}, {63'd0, we});
        check("alu_wb_waddr", {59'd0, wb_reg_waddr_o}, {59'd0, waddr});
        check("alu_wb_wdata", {32'd0, wb_reg_wdata_o}, {32'd0, wdata});
        check("alu_req_next", {63'd0, dbus_req_o}, 64'd0);
    endtask

    task automatic mem_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] waddr, input int wait_cycles,
                          input logic [31:0] rdata, input bit ack_in_idle);
        bit is_ld;
        is_ld       = (op >= OP_LB);
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_data_i  = data;
        mem_we_i    = !is_ld;
        reg_waddr_i = waddr;
        reg_we_i    = is_ld;
        reg_wdata_i = $urandom;
        dbus_ack_i  = ack_in_idle;
        dbus_rdata_i = $urandom;
        @(negedge clk_i);
        check("idle_stall", {63'd0, stall_o}, 64'd1);
        check("idle_req", {63'd0, dbus_req_o}, 64'd0);
        @(posedge clk_i); #1;
        check("bubble", {63'd0, wb_reg_we_o}, 64'd0);
        for (int i = 0; i <= wait_cycles; i++) begin
            dbus_ack_i   = (i == wait_cycles);
            dbus_rdata_i = (i == wait_cycles) ? rdata : $urandom;
            @(negedge clk_i);
            check("bus_req", {63'd0, dbus_req_o}, 64'd1);
            check("bus_we", {63'd0, dbus_we_o}, {63'd0, !is_ld});
            check("bus_addr", {32'd0, dbus_addr_o}, {32'd0, addr[31:2], 2'b00});
            check("bus_be", {60'd0, dbus_be_o}, {60'd0, store_be(op, addr)});
            check("bus_stall", {63'd0, stall_o}, {63'd0, (i != wait_cycles)});
            check("bus_wb_idle", {63'd0, wb_reg_we_o}, 64'd0);
            if (!is_ld) check("bus_wdata", {32'd0, dbus_wdata_o}, {32'd0, store_wdata(op, data)});
            if (is_ld && (i == wait_cycles)) exp_q.push_back({waddr, load_model(op, addr, rdata)});
            @(posedge clk_i); #1;
        end
        dbus_ack_i = 1'b0;
        check("ack_wb_we", {63'd0, wb_reg_we_o}, {63'd0, is_ld});
        check("ack_req_drop", {63'd0, dbus_req_o}, 64'd0);
        mem_op_i = OP_NOP;
        reg_we_i = 1'b0;
        mem_we_i = 1'b0;
    endtask

    logic [31:0] r_addr;
    logic [3:0]  r_op;
    int          r_kind;

    initial begin
        rst_i        = 1'b1;
        reg_waddr_i  = '0;
        reg_we_i     = 1'b1;
        reg_wdata_i  = 32'h5555_AAAA;
        mem_addr_i   = 32'h10;
        mem_data_i   = '0;
        mem_we_i     = 1'b0;
        mem_op_i     = OP_LW;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_req", {63'd0, dbus_req_o}, 64'd0);
        check("rst_bus_we", {63'd0, dbus_we_o}, 64'd0);
        check("rst_bus_addr", {32'd0, dbus_addr_o}, 64'd0);
        check("rst_bus_wdata", {32'd0, dbus_wdata_o}, 64'd0);
        check("rst_bus_be", {60'd0, dbus_be_o}, 64'd0);
        check("rst_wb", {wb_reg_waddr_o, wb_reg_we_o, wb_reg_wdata_o}, 64'd0);
        mem_op_i = OP_NOP;
        reg_we_i = 1'b0;
        rst_i    = 1'b0;
        @(posedge clk_i); #1;

        alu_op(5'd5, 32'h1234, 1'b1, OP_NOP, 1'b0);
        mem_op(OP_SB, 32'h103, 32'hAB, 5'd7, 3, 32'h0, 1'b0);
        mem_op(OP_LB, 32'h102, 32'h0, 5'd3, 0, 32'h0080_FF00, 1'b0);
        mem_op(OP_LBU, 32'h102, 32'h0, 5'd4, 0, 32'h0080_FF00, 1'b0);
        mem_op(OP_LH, 32'h2, 32'h0, 5'd9, 0, 32'h8001_0000, 1'b0);
        mem_op(OP_LW, 32'h20, 32'h0, 5'd10, 1, 32'h1357_9BDF, 1'b0);
        mem_op(OP_SW, 32'h24, 32'hDEAD_BEEF, 5'd11, 0, 32'h0, 1'b0);
        alu_op(5'd6, 32'h55, 1'b1, OP_NOP, 1'b1);
        mem_op(OP_LHU, 32'h6, 32'h0, 5'd4, 0, 32'hBEEF_1234, 1'b1);
        alu_op(5'd8, 32'hCAFE_0001, 1'b1, 4'd12, 1'b0);
        alu_op(5'd2, 32'h0BAD_0BAD, 1'b0, OP_NOP, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        mem_op_i    = OP_LW;
        mem_addr_i  = 32'h6;
        reg_waddr_i = 5'd12;
        reg_we_i    = 1'b1;
        @(negedge clk_i);
        check("mis_stall", {63'd0, stall_o}, 64'd0);
        check("mis_req", {63'd0, dbus_req_o}, 64'd0);
        @(posedge clk_i); #1;
        mem_op_i = OP_NOP;
        reg_we_i = 1'b0;
        check("mis_pulse", {63'd0, misalign_o}, 64'd1);
        check("mis_addr", {32'd0, misalign_addr_o}, 64'h6);
        check("mis_wb_we", {63'd0, wb_reg_we_o}, 64'd0);
        check("mis_req_next", {63'd0, dbus_req_o}, 64'd0);
        @(posedge clk_i); #1;
        check("mis_pulse_end", {63'd0, misalign_o}, 64'd0);
`else
        mem_op(OP_LW, 32'h6, 32'h0, 5'd12, 1, 32'hCAFE_F00D, 1'b0);
        mem_op(OP_SH, 32'h103, 32'h1234_ABCD, 5'd13, 0, 32'h0, 1'b0);
        mem_op(OP_LHU, 32'h101, 32'h0, 5'd14, 0, 32'hFACE_8765, 1'b0);
`endif

        // Reset in the middle of a bus transaction abandons it.
        mem_op_i    = OP_LW;
        mem_addr_i  = 32'h40;
        reg_waddr_i = 5'd11;
        reg_we_i    = 1'b1;
        @(posedge clk_i); #1;
        check("rstbus_req_pre", {63'd0, dbus_req_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        check("rstbus_req_drop", {63'd0, dbus_req_o}, 64'd0);
        check("rstbus_stall", {63'd0, stall_o}, 64'd0);
        mem_op_i = OP_NOP;
        reg_we_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = 32'h7777_7777;
        @(negedge clk_i);
        check("rstbus_ack_req", {63'd0, dbus_req_o}, 64'd0);
        @(posedge clk_i); #1;
        dbus_ack_i = 1'b0;
        check("rstbus_no_wb", {63'd0, wb_reg_we_o}, 64'd0);

        for (int n = 0; n < 40; n++) begin
            r_kind = $urandom_range(0, 2);
            if (r_kind == 0) begin
                r_op = ($urandom_range(0, 1) == 0) ? OP_NOP : 4'($urandom_range(9, 15));
                alu_op(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), r_op, 1'($urandom_range(0, 1)));
            end else begin
                r_op   = 4'($urandom_range(1, 8));
                r_addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
                if ((r_op == OP_SH) || (r_op == OP_LH) || (r_op == OP_LHU)) r_addr[0] = 1'b0;
                if ((r_op == OP_SW) || (r_op == OP_LW)) r_addr[1:0] = 2'b00;
`endif
                mem_op(r_op, r_addr, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                       $urandom, 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk_i);
        @(negedge clk_i);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
